// File: rtl/cam_config_sequencer_if.sv
// Command port between cam_config_sequencer (master) and i2c_master (slave).
// Strobe/ready handshake carrying one SCCB write per transaction.
interface cam_config_sequencer_if;
   logic [15:0] i2c_addr_data;
   logic        i2c_cmd;
   logic        i2c_strobe;
   logic        i2c_ready;
   logic [2:0]  i2c_status;

   modport master (
      output i2c_addr_data, i2c_cmd, i2c_strobe,
      input  i2c_ready, i2c_status
   );

   modport slave (
      input  i2c_addr_data, i2c_cmd, i2c_strobe,
      output i2c_ready, i2c_status
   );
endinterface

// File: rtl/cam_config_sequencer.sv
// Walks the OV7675 init table, one SCCB write per entry, with delay entries and NACK retry.
// Optional transaction watchdog enabled by defining CAM_CFG_TIMEOUT_EN.
module cam_config_sequencer #(
   parameter int unsigned CONFIG_LENGTH = 198,
   parameter int unsigned IDX_W         = 8,
   parameter int unsigned DELAY_UNIT    = 100000,
   parameter int unsigned MAX_RETRY     = 3,
   parameter int unsigned TIMEOUT_CYC   = 2000000
) (
   input  logic                   clk_100,
   input  logic                   rst_n,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic [IDX_W-1:0]       err_index,
   output logic [IDX_W-1:0]       rom_index,
   input  logic [15:0]            rom_entry,
   cam_config_sequencer_if.master i2c
);

   localparam int unsigned RW = $clog2(MAX_RETRY + 2);

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_ISSUE,
      S_WAIT_ACCEPT,
      S_WAIT_DONE,
      S_DELAY,
      S_NEXT,
      S_DONE,
      S_ERROR
   } state_t;

   state_t           r_state;
   logic [IDX_W-1:0] r_idx;
   logic [15:0]      r_entry;
   logic [RW-1:0]    r_retry;
   logic [31:0]      r_dly;
   logic             r_fetch_ph;
   logic             r_armed;
   logic             r_busy;
   logic             r_done;
   logic             r_error;
   logic [IDX_W-1:0] r_err_index;
   logic [15:0]      r_addr_data;
   logic             r_strobe;
`ifdef CAM_CFG_TIMEOUT_EN
   logic [31:0]      r_wd;
`endif

   assign busy              = r_busy;
   assign done              = r_done;
   assign error             = r_error;
   assign err_index         = r_err_index;
   assign rom_index         = r_idx;
   assign i2c.i2c_addr_data = r_addr_data;
   assign i2c.i2c_cmd       = 1'b0;
   assign i2c.i2c_strobe    = r_strobe;

   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_entry     <= '0;
         r_retry     <= '0;
         r_dly       <= '0;
         r_fetch_ph  <= 1'b0;
         r_armed     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_err_index <= '0;
         r_addr_data <= '0;
         r_strobe    <= 1'b0;
`ifdef CAM_CFG_TIMEOUT_EN
         r_wd        <= '0;
`endif
      end else begin
         // r_armed masks a start that lands on the first edge after reset release
         r_armed  <= 1'b1;
         r_strobe <= 1'b0;
`ifdef CAM_CFG_TIMEOUT_EN
         if (r_state inside {S_ISSUE, S_WAIT_ACCEPT, S_WAIT_DONE})
            r_wd <= r_wd + 1'b1;
`endif
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start && r_armed) begin
                  r_idx      <= '0;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_error    <= 1'b0;
                  r_fetch_ph <= 1'b0;
                  r_state    <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (!r_fetch_ph) begin
                  r_fetch_ph <= 1'b1;
               end else begin
                  r_fetch_ph <= 1'b0;
                  r_entry    <= rom_entry;
                  r_state    <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (r_entry[15:8] == 8'hFF) begin
                  r_dly   <= 32'(r_entry[7:0]) * 32'(DELAY_UNIT);
                  r_state <= S_DELAY;
               end else begin
                  r_retry <= '0;
`ifdef CAM_CFG_TIMEOUT_EN
                  r_wd    <= '0;
`endif
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (i2c.i2c_ready) begin
                  r_strobe    <= 1'b1;
                  r_addr_data <= r_entry;
                  r_state     <= S_WAIT_ACCEPT;
               end
            end
            S_WAIT_ACCEPT: begin
               if (!i2c.i2c_ready)
                  r_state <= S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               if (i2c.i2c_ready) begin
                  if (i2c.i2c_status == 3'b000) begin
                     r_state <= S_NEXT;
                  end else if (r_retry < RW'(MAX_RETRY)) begin
                     r_retry <= r_retry + 1'b1;
`ifdef CAM_CFG_TIMEOUT_EN
                     r_wd    <= '0;
`endif
                     r_state <= S_ISSUE;
                  end else begin
                     r_err_index <= r_idx;
                     r_busy      <= 1'b0;
                     r_error     <= 1'b1;
                     r_state     <= S_ERROR;
                  end
               end
            end
            S_DELAY: begin
               // a zero-tick entry still spends one cycle here
               if (r_dly <= 32'd1)
                  r_state <= S_NEXT;
               else
                  r_dly <= r_dly - 1'b1;
            end
            S_NEXT: begin
               if (r_idx == IDX_W'(CONFIG_LENGTH - 1)) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_idx      <= r_idx + 1'b1;
                  r_fetch_ph <= 1'b0;
                  r_state    <= S_FETCH;
               end
            end
            default: r_state <= S_IDLE;
         endcase
`ifdef CAM_CFG_TIMEOUT_EN
         // watchdog wins over any handshake progress on the same edge; no retry
         if ((r_state inside {S_ISSUE, S_WAIT_ACCEPT, S_WAIT_DONE}) &&
             (r_wd >= 32'(TIMEOUT_CYC - 1))) begin
            r_strobe    <= 1'b0;
            r_err_index <= r_idx;
            r_busy      <= 1'b0;
            r_error     <= 1'b1;
            r_state     <= S_ERROR;
         end
`endif
      end
   end

endmodule

// File: tb/tb_cam_config_sequencer.sv
// Directed bench for cam_config_sequencer: 4-entry table, i2c_master model acking after 20 cycles.
// Watchdog expectations follow CAM_CFG_TIMEOUT_EN.
module tb_cam_config_sequencer;
   logic        clk;
   logic        rst_n;
   logic        start;
   logic        busy;
   logic        done;
   logic        error;
   logic [7:0]  err_index;
   logic [7:0]  rom_index;
   logic [15:0] rom_entry;

   cam_config_sequencer_if ifc ();

   cam_config_sequencer #(
      .CONFIG_LENGTH (4),
      .IDX_W         (8),
      .DELAY_UNIT    (10),
      .MAX_RETRY     (3),
      .TIMEOUT_CYC   (50)
   ) dut (
      .clk_100   (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .err_index (err_index),
      .rom_index (rom_index),
      .rom_entry (rom_entry),
      .i2c       (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [15:0] rom [256];
   always @(posedge clk) rom_entry <= rom[rom_index];

   // strobe monitor
   logic [15:0] slog [$];
   int cmd_viol    = 0;
   int strobe_viol = 0;
   always @(posedge clk) begin
      if (ifc.i2c_strobe === 1'b1) begin
         slog.push_back(ifc.i2c_addr_data);
         if (ifc.i2c_ready !== 1'b1) strobe_viol++;
      end
      if (rst_n === 1'b1 && ifc.i2c_cmd !== 1'b0) cmd_viol++;
   end

   // i2c_master model: ready drops after a strobe, returns 20 cycles later
   logic        m_rst;
   logic        stuck;
   logic [15:0] nack_data;
   int          nack_limit;
   int          s0;
   logic        m_busy;
   int          m_cnt;
   logic [15:0] m_data;
   always @(posedge clk) begin
      if (m_rst) begin
         m_busy         <= 1'b0;
         m_cnt          <= 0;
         m_data         <= '0;
         ifc.i2c_ready  <= 1'b1;
         ifc.i2c_status <= 3'b000;
      end else if (m_busy) begin
         if (!stuck) begin
            if (m_cnt >= 19) begin
               automatic int hits = 0;
               for (int i = s0; i < slog.size(); i++)
                  if (slog[i] == nack_data) hits++;
               m_busy        <= 1'b0;
               ifc.i2c_ready <= 1'b1;
               ifc.i2c_status <= (m_data == nack_data && hits <= nack_limit) ? 3'b001 : 3'b000;
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end
      end else if (ifc.i2c_strobe === 1'b1) begin
         m_busy         <= 1'b1;
         m_cnt          <= 0;
         m_data         <= ifc.i2c_addr_data;
         ifc.i2c_ready  <= 1'b0;
         ifc.i2c_status <= 3'b101;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end(input string tag, input int budget);
      int n = 0;
      while (!(done || error) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_finished"}, 32'(done || error), 32'd1);
   endtask

   task automatic chk_strobes(input string tag, input logic [15:0] exp [$]);
      chk({tag, "_count"}, 32'(slog.size() - s0), 32'(exp.size()));
      for (int i = 0; i < exp.size(); i++)
         if (s0 + i < slog.size())
            chk($sformatf("%s_val%0d", tag, i), 32'(slog[s0 + i]), 32'(exp[i]));
   endtask

   initial begin
      int n;
      rst_n = 1'b0; start = 1'b0; m_rst = 1'b1; stuck = 1'b0;
      nack_data = 16'h0000; nack_limit = 0; s0 = 0;
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      rom[0] = 16'h1280; rom[1] = 16'h3A04; rom[2] = 16'h1200; rom[3] = 16'h1713;
      repeat (3) @(negedge clk);
      m_rst = 1'b0;

      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_err_index", 32'(err_index), 32'd0);
      chk("rst_rom_index", 32'(rom_index), 32'd0);
      chk("rst_addr_data", 32'(ifc.i2c_addr_data), 32'd0);
      chk("rst_cmd", 32'(ifc.i2c_cmd), 32'd0);
      chk("rst_strobe", 32'(ifc.i2c_strobe), 32'd0);

      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // plain four-entry run
      s0 = slog.size();
      pulse_start();
      chk("t1_busy_after_start", 32'(busy), 32'd1);
      n = 0;
      while (ifc.i2c_strobe !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t1_start_to_strobe", 32'(n), 32'd4);
      wait_end("t1", 2000);
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_error", 32'(error), 32'd0);
      chk_strobes("t1", '{16'h1280, 16'h3A04, 16'h1200, 16'h1713});

      // delay entries: 2 ticks then 0 ticks
      rom[1] = 16'hFF02; rom[2] = 16'hFF00;
      repeat (3) @(negedge clk);
      s0 = slog.size();
      pulse_start();
      n = 0;
      while (rom_index != 8'd1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (rom_index == 8'd1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t2_delay2_span", 32'(n), 32'd24);
      n = 0;
      while (rom_index == 8'd2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t2_delay0_span", 32'(n), 32'd5);
      wait_end("t2", 2000);
      chk("t2_done", 32'(done), 32'd1);
      chk_strobes("t2", '{16'h1280, 16'h1713});

      // two NACKs on idx 1 then ACK
      rom[1] = 16'h3A04; rom[2] = 16'h1200;
      nack_data = 16'h3A04; nack_limit = 2;
      repeat (3) @(negedge clk);
      s0 = slog.size();
      pulse_start();
      wait_end("t3", 3000);
      chk("t3_done", 32'(done), 32'd1);
      chk("t3_error", 32'(error), 32'd0);
      chk_strobes("t3", '{16'h1280, 16'h3A04, 16'h3A04, 16'h3A04, 16'h1200, 16'h1713});

      // persistent NACK on idx 2
      nack_data = 16'h1200; nack_limit = 100;
      repeat (3) @(negedge clk);
      s0 = slog.size();
      pulse_start();
      wait_end("t4", 3000);
      chk("t4_error", 32'(error), 32'd1);
      chk("t4_err_index", 32'(err_index), 32'd2);
      chk("t4_busy", 32'(busy), 32'd0);
      chk("t4_done", 32'(done), 32'd0);
      chk_strobes("t4", '{16'h1280, 16'h3A04, 16'h1200, 16'h1200, 16'h1200, 16'h1200});
      nack_limit = 0;

      // reset during WAIT_DONE of idx 1
      repeat (3) @(negedge clk);
      s0 = slog.size();
      pulse_start();
      n = 0;
      while ((slog.size() - s0) < 2 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("t5_reached_idx1", 32'(slog.size() - s0), 32'd2);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_busy", 32'(busy), 32'd0);
      chk("t5_rst_error", 32'(error), 32'd0);
      chk("t5_rst_err_index", 32'(err_index), 32'd0);
      chk("t5_rst_rom_index", 32'(rom_index), 32'd0);
      chk("t5_rst_addr_data", 32'(ifc.i2c_addr_data), 32'd0);
      chk("t5_rst_strobe", 32'(ifc.i2c_strobe), 32'd0);
      repeat (25) @(negedge clk);
      rst_n = 1'b1;
      pulse_start();
      @(negedge clk);
      chk("t5_start_at_release_ignored", 32'(busy), 32'd0);
      s0 = slog.size();
      pulse_start();
      n = 0;
      while ((slog.size() - s0) < 2 && n < 500) begin
         @(negedge clk);
         n++;
      end
      pulse_start();
      wait_end("t5", 3000);
      chk("t5_done", 32'(done), 32'd1);
      chk_strobes("t5", '{16'h1280, 16'h3A04, 16'h1200, 16'h1713});
      chk("cmd_always_write", 32'(cmd_viol), 32'd0);
      chk("no_strobe_while_not_ready", 32'(strobe_viol), 32'd0);

      // i2c_ready stuck low after the idx 0 strobe
      stuck = 1'b1;
      repeat (3) @(negedge clk);
      s0 = slog.size();
      pulse_start();
      n = 0;
      while (ifc.i2c_strobe !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t6_strobe_seen", 32'(ifc.i2c_strobe), 32'd1);
      n = 0;
      while (error !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
`ifdef CAM_CFG_TIMEOUT_EN
      chk("t6_timeout_cycles", 32'(n), 32'd49);
      chk("t6_error", 32'(error), 32'd1);
      chk("t6_err_index", 32'(err_index), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
`else
      chk("t6_busy_stuck", 32'(busy), 32'd1);
      chk("t6_no_error", 32'(error), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
